// File: rtl/exc_controller.sv
// ---------------------------------------------------------------------------
// exc_controller
//   Exception sequencer for the pipelined LEGv8 core. Exception request
//   pulses are latched into a pending vector. The lowest-index pending and
//   enabled source wins arbitration. The pipeline is then drained for
//   FLUSH_CYCLES cycles. After that, a one-cycle Exc pulse is issued with
//   the cause code. The block then waits for the fetch stage to reach the
//   vector (ExcAck), and finally tracks the handler until ERet. Nested
//   exceptions are not dispatched: new requests only accumulate in pending
//   until the handler returns.
//
// Ports
//   clk          in   core clock
//   reset        in   asynchronous, active-high reset
//   exc_req      in   [NSRC]  single-cycle request pulses, one per source
//   exc_en       in   [NSRC]  per-source dispatch enable mask
//   ERet         in   ERET instruction in EX this cycle
//   ExcAck       in   fetch address equals exception vector
//   Exc          out  one-cycle pulse: enter exception
//   EStatus      out  [4]  cause = winning index + 1, 0 = none
//   flush        out  squash IF/ID/EX pipeline registers
//   stall_F      out  hold PC / fetch stage
//   in_handler   out  handler executing
//   pending      out  [NSRC] latched, not-yet-dispatched requests
//   timeout_err  out  sticky: ExcAck never arrived
// ---------------------------------------------------------------------------
module exc_controller #(
  parameter int NSRC         = 4,
  parameter int FLUSH_CYCLES = 3,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] exc_req,
  input  logic [NSRC-1:0] exc_en,
  input  logic            ERet,
  input  logic            ExcAck,
  output logic            Exc,
  output logic [3:0]      EStatus,
  output logic            flush,
  output logic            stall_F,
  output logic            in_handler,
  output logic [NSRC-1:0] pending,
  output logic            timeout_err
);

  localparam int CNT_MAX = (FLUSH_CYCLES > ACK_TIMEOUT) ? FLUSH_CYCLES : ACK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_SIGNAL   = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_HANDLER  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [3:0]      r_cause;
  logic [3:0]      w_cause_next;
  logic [NSRC-1:0] r_pending;
  logic            r_timeout_err;
  logic            w_set_timeout;
  logic [NSRC-1:0] w_eligible;
  logic [NSRC-1:0] w_clr;
  logic [3:0]      w_win_idx;

  assign w_eligible = r_pending & exc_en;

  // Lowest set index wins; iterate downward so the last hit is the lowest.
  always_comb begin
    w_win_idx = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_win_idx = i[3:0];
    end
  end

  // Pending bits: a new request on the same edge as the dispatch clear wins,
  // so a re-request during SIGNAL is kept as a fresh event.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_pending
      assign w_clr[gi] = (r_state == S_SIGNAL) && (r_cause == 4'(gi + 1));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pending[gi] <= 1'b0;
        else       r_pending[gi] <= exc_req[gi] | (r_pending[gi] & ~w_clr[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cause       <= 4'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_cause <= w_cause_next;
      if (w_set_timeout) r_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_cause_next  = r_cause;
    w_set_timeout = 1'b0;
    Exc           = 1'b0;
    EStatus       = 4'd0;
    flush         = 1'b0;
    stall_F       = 1'b0;
    in_handler    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|w_eligible) begin
          w_state_next = S_DRAIN;
          w_cnt_next   = CW'(FLUSH_CYCLES - 1);
          w_cause_next = w_win_idx + 4'd1;
        end
      end
      S_DRAIN: begin
        flush   = 1'b1;
        stall_F = 1'b1;
        if (r_cnt == '0) w_state_next = S_SIGNAL;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      S_SIGNAL: begin
        Exc          = 1'b1;
        flush        = 1'b1;
        EStatus      = r_cause;
        w_cnt_next   = '0;
        w_state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        EStatus = r_cause;
        // ExcAck takes precedence over a timeout on the same cycle.
        if (ExcAck) begin
          w_state_next = S_HANDLER;
        end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
          w_set_timeout = 1'b1;
          w_state_next  = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_HANDLER: begin
        in_handler = 1'b1;
        EStatus    = r_cause;
        // ERET squashes the younger instructions behind it this same cycle.
        if (ERet) begin
          flush        = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign pending     = r_pending;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_exc_controller.sv
module tb_exc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] exc_req;
  logic [3:0] exc_en;
  logic       ERet;
  logic       ExcAck;
  logic       Exc;
  logic [3:0] EStatus;
  logic       flush;
  logic       stall_F;
  logic       in_handler;
  logic [3:0] pending;
  logic       timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  exc_controller #(.NSRC(4), .FLUSH_CYCLES(3), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_en(exc_en),
    .ERet(ERet), .ExcAck(ExcAck), .Exc(Exc), .EStatus(EStatus),
    .flush(flush), .stall_F(stall_F), .in_handler(in_handler),
    .pending(pending), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // {Exc, EStatus, flush, stall_F, in_handler, pending, timeout_err}
  function automatic logic [12:0] outs();
    return {Exc, EStatus, flush, stall_F, in_handler, pending, timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // From WAIT_ACK: acknowledge, enter handler, return.
  task automatic finish_handler();
    ExcAck = 1'b1;
    tick();
    ExcAck = 1'b0;
    ERet = 1'b1;
    tick();
    ERet = 1'b0;
  endtask

  task automatic pulse_req(input logic [3:0] r);
    exc_req = r;
    tick();
    exc_req = 4'b0000;
  endtask

  task automatic test_reset();
    reset = 1'b1; exc_req = '0; exc_en = 4'b1111; ERet = 0; ExcAck = 0;
    ticks(2);
    n_checks++;
    if (outs() !== 13'd0) $display("FAIL reset_hold outs=%h expected=%h", outs(), 13'd0);
    else n_pass++;
    reset = 1'b0;
    pulse_req(4'b0001);
    tick();
    n_checks++;
    if ({flush, stall_F} !== 2'b11) $display("FAIL drain_before_reset flush/stall=%b expected=11", {flush, stall_F});
    else n_pass++;
    tick();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (outs() !== 13'd0) $display("FAIL async_reset outs=%h expected=%h", outs(), 13'd0);
    else n_pass++;
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (outs() !== 13'd0) $display("FAIL post_reset_idle outs=%h expected=%h", outs(), 13'd0);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    pulse_req(4'b0100);
    n_checks++;
    if ({pending, flush} !== 5'b0100_0) $display("FAIL single_latch pending/flush=%b expected=01000", {pending, flush});
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({Exc, flush, stall_F} !== 3'b011) $display("FAIL single_drain%0d exc/flush/stall=%b expected=011", k, {Exc, flush, stall_F});
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({Exc, EStatus, flush, stall_F} !== 7'b1_0011_1_0) $display("FAIL single_signal got=%b expected=1001110", {Exc, EStatus, flush, stall_F});
    else n_pass++;
    tick();
    n_checks++;
    if ({Exc, EStatus, flush, pending} !== 10'b0_0011_0_0000) $display("FAIL single_wait got=%b expected=0001100000", {Exc, EStatus, flush, pending});
    else n_pass++;
    tick();
    ExcAck = 1'b1;
    tick();
    ExcAck = 1'b0;
    n_checks++;
    if ({in_handler, EStatus} !== 5'b1_0011) $display("FAIL single_handler got=%b expected=10011", {in_handler, EStatus});
    else n_pass++;
    ERet = 1'b1;
    #1;
    n_checks++;
    if (flush !== 1'b1) $display("FAIL eret_flush got=%b expected=1", flush);
    else n_pass++;
    tick();
    ERet = 1'b0;
    n_checks++;
    if ({in_handler, EStatus, flush} !== 6'b0_0000_0) $display("FAIL single_return got=%b expected=000000", {in_handler, EStatus, flush});
    else n_pass++;
    $display("test_single done");
  endtask

  task automatic test_priority();
    pulse_req(4'b1010);
    ticks(4);
    n_checks++;
    if ({Exc, EStatus} !== 5'b1_0010) $display("FAIL prio_first got=%b expected=10010", {Exc, EStatus});
    else n_pass++;
    tick();
    n_checks++;
    if (pending !== 4'b1000) $display("FAIL prio_pending got=%b expected=1000", pending);
    else n_pass++;
    finish_handler();
    n_checks++;
    if ({flush, EStatus} !== 5'b0_0000) $display("FAIL prio_idle got=%b expected=00000", {flush, EStatus});
    else n_pass++;
    tick();
    n_checks++;
    if ({flush, stall_F} !== 2'b11) $display("FAIL back_to_back_drain got=%b expected=11", {flush, stall_F});
    else n_pass++;
    ticks(3);
    n_checks++;
    if ({Exc, EStatus} !== 5'b1_0100) $display("FAIL prio_second got=%b expected=10100", {Exc, EStatus});
    else n_pass++;
    tick();
    finish_handler();
    $display("test_priority done");
  endtask

  task automatic test_masking();
    exc_en = 4'b1110;
    pulse_req(4'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if ({Exc, flush} !== 2'b00) $display("FAIL mask_nodispatch%0d got=%b expected=00", k, {Exc, flush});
      else n_pass++;
    end
    n_checks++;
    if (pending !== 4'b0001) $display("FAIL mask_pending got=%b expected=0001", pending);
    else n_pass++;
    exc_en = 4'b1111;
    ticks(4);
    n_checks++;
    if ({Exc, EStatus} !== 5'b1_0001) $display("FAIL mask_dispatch got=%b expected=10001", {Exc, EStatus});
    else n_pass++;
    tick();
    finish_handler();
    $display("test_masking done");
  endtask

  task automatic test_timeout();
    pulse_req(4'b0001);
    ticks(4);
    n_checks++;
    if (Exc !== 1'b1) $display("FAIL to_signal got=%b expected=1", Exc);
    else n_pass++;
    ticks(16);
    n_checks++;
    if ({EStatus, timeout_err} !== 5'b0001_0) $display("FAIL to_cycle16 got=%b expected=00010", {EStatus, timeout_err});
    else n_pass++;
    tick();
    n_checks++;
    if ({EStatus, timeout_err} !== 5'b0000_1) $display("FAIL to_fire got=%b expected=00001", {EStatus, timeout_err});
    else n_pass++;
    ticks(3);
    n_checks++;
    if ({timeout_err, flush} !== 2'b10) $display("FAIL to_sticky got=%b expected=10", {timeout_err, flush});
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulse_req(4'b0001);
    ticks(4);
    ticks(16);
    ExcAck = 1'b1;
    tick();
    ExcAck = 1'b0;
    n_checks++;
    if ({in_handler, timeout_err} !== 2'b10) $display("FAIL ack_last_cycle got=%b expected=10", {in_handler, timeout_err});
    else n_pass++;
    ERet = 1'b1;
    tick();
    ERet = 1'b0;
    $display("test_timeout done");
  endtask

  task automatic test_no_nesting();
    pulse_req(4'b0001);
    ticks(4);
    tick();
    ExcAck = 1'b1;
    tick();
    ExcAck = 1'b0;
    pulse_req(4'b0010);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({Exc, in_handler, pending} !== 6'b0_1_0010) $display("FAIL nest_blocked%0d got=%b expected=010010", k, {Exc, in_handler, pending});
      else n_pass++;
      tick();
    end
    ERet = 1'b1;
    tick();
    ERet = 1'b0;
    n_checks++;
    if ({in_handler, pending} !== 5'b0_0010) $display("FAIL nest_after_eret got=%b expected=00010", {in_handler, pending});
    else n_pass++;
    ticks(4);
    n_checks++;
    if ({Exc, EStatus} !== 5'b1_0010) $display("FAIL nest_dispatch got=%b expected=10010", {Exc, EStatus});
    else n_pass++;
    pulse_req(4'b0010);
    n_checks++;
    if (pending !== 4'b0010) $display("FAIL set_wins got=%b expected=0010", pending);
    else n_pass++;
    finish_handler();
    ticks(4);
    n_checks++;
    if ({Exc, EStatus} !== 5'b1_0010) $display("FAIL redispatch got=%b expected=10010", {Exc, EStatus});
    else n_pass++;
    tick();
    finish_handler();
    n_checks++;
    if (pending !== 4'b0000) $display("FAIL final_pending got=%b expected=0000", pending);
    else n_pass++;
    $display("test_no_nesting done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_timeout();
    test_no_nesting();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
